// File: rtl/regfile_sequencer.sv
// Command sequencer in front of a 4-entry N-bit register file: LOAD/MOV/ADD/READ -> RF cycles.
// Optional feature macro: CARRY_FLAG_EN adds a registered ADD carry output.
module regfile_sequencer #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [1:0]   cmd_rd,
  input  logic [1:0]   cmd_rs,
  input  logic [N-1:0] cmd_imm,
  output logic [N-1:0] rf_din,
  output logic         rf_wa0,
  output logic         rf_wa1,
  output logic         rf_wren,
  output logic         rf_ra0,
  output logic         rf_ra1,
  input  logic [N-1:0] rf_dout,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  output logic         busy
`ifdef CARRY_FLAG_EN
  ,output logic        carry
`endif
);

  typedef enum logic [2:0] {IDLE, RD_S, RD_D, WRITE, RESP} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  state_t       state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [1:0]   rd_q, rd_d;
  logic [1:0]   rs_q, rs_d;
  logic [N-1:0] imm_q, imm_d;
  logic [N-1:0] opa_q, opa_d;
  logic [N-1:0] opb_q, opb_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic [N-1:0] sum;
  logic [1:0]   ra, wa;

  assign cmd_ready = (state_q == IDLE) && !RST;
  assign sum       = opa_q + opb_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RESP);
  assign res_data  = res_data_q;
  assign rf_ra0    = ra[0];
  assign rf_ra1    = ra[1];
  assign rf_wa0    = wa[0];
  assign rf_wa1    = wa[1];

`ifdef CARRY_FLAG_EN
  logic [N:0] sum_ext;
  logic       carry_q, carry_d;
  assign sum_ext = {1'b0, opa_q} + {1'b0, opb_q};
  assign carry   = carry_q;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    imm_d      = imm_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_data_d = res_data_q;
    ra         = 2'b00;
    wa         = 2'b00;
    rf_wren    = 1'b0;
    rf_din     = '0;
`ifdef CARRY_FLAG_EN
    carry_d    = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          rd_d    = cmd_rd;
          rs_d    = cmd_rs;
          imm_d   = cmd_imm;
          state_d = (cmd_op == OP_LOAD) ? WRITE : RD_S;
        end
      end
      RD_S: begin
        ra    = rs_q;
        opb_d = rf_dout;
        case (op_q)
          OP_MOV:  state_d = WRITE;
          OP_ADD:  state_d = RD_D;
          default: begin
            // READ result is registered here so it is visible throughout RESP and held after
            res_data_d = rf_dout;
            state_d    = RESP;
          end
        endcase
      end
      RD_D: begin
        ra      = rd_q;
        opa_d   = rf_dout;
        state_d = WRITE;
      end
      WRITE: begin
        rf_wren = 1'b1;
        wa      = rd_q;
        case (op_q)
          OP_LOAD: rf_din = imm_q;
          OP_MOV:  rf_din = opb_q;
          default: rf_din = sum;
        endcase
`ifdef CARRY_FLAG_EN
        if (op_q == OP_ADD) carry_d = sum_ext[N];
`endif
        state_d = IDLE;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      rd_q       <= 2'b00;
      rs_q       <= 2'b00;
      imm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_data_q <= '0;
`ifdef CARRY_FLAG_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      imm_q      <= imm_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_data_q <= res_data_d;
`ifdef CARRY_FLAG_EN
      carry_q    <= carry_d;
`endif
    end
  end

  // OP_READ is the default arm above; keep the name referenced for readers
  logic unused_ok;
  assign unused_ok = (OP_READ == 2'b11);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file plus a plain-array reference model.
module tb_regfile_sequencer;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op, cmd_rd, cmd_rs;
  logic [N-1:0] cmd_imm;
  logic [N-1:0] rf_din;
  logic         rf_wa0, rf_wa1, rf_wren, rf_ra0, rf_ra1;
  logic [N-1:0] rf_dout;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         busy;
`ifdef CARRY_FLAG_EN
  logic         carry;
`endif

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int res_count = 0;
  logic [N-1:0] last_res;

  logic [N-1:0] rf_mem [4];
  int           ref_rf [4];
  bit           ref_carry;

  always #5 CLK = ~CLK;

  regfile_sequencer #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rf_din(rf_din), .rf_wa0(rf_wa0), .rf_wa1(rf_wa1), .rf_wren(rf_wren),
    .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_dout(rf_dout),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
`ifdef CARRY_FLAG_EN
    , .carry(carry)
`endif
  );

  // Register file environment: resets with RST, writes on WrEn, combinational read
  assign rf_dout = rf_mem[{rf_ra1, rf_ra0}];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
    end else begin
      if (rf_wren) rf_mem[{rf_wa1, rf_wa0}] <= rf_din;
      if (rf_wren) wr_count <= wr_count + 1;
      if (res_valid) res_count <= res_count + 1;
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 4; i++) ref_rf[i] = 0;
    ref_carry = 1'b0;
  endtask

  // Drive one command and check every cycle until the sequencer is idle again
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [N-1:0] imm, input bit hold);
    int lat, w, wr0, res0, sum;
    logic [N-1:0] exp_val;
    logic [1:0]   exp_ra;
    logic         exp_wren, exp_resv;
    bit           exp_carry;
    sum       = ref_rf[rd] + ref_rf[rs];
    exp_carry = ref_carry;
    case (op)
      2'b00: begin lat = 1; exp_val = imm; end
      2'b01: begin lat = 2; exp_val = ref_rf[rs][N-1:0]; end
      2'b10: begin lat = 3; exp_val = sum[N-1:0]; exp_carry = (sum >= (1 << N)); end
      default: begin lat = 2; exp_val = ref_rf[rs][N-1:0]; end
    endcase
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge CLK); w++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    wr0 = wr_count; res0 = res_count;
    @(posedge CLK);
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      if (!hold) cmd_valid = 1'b0;
      exp_wren = (k == lat) && (op != 2'b11);
      exp_resv = (k == lat) && (op == 2'b11);
      exp_ra = 2'b00;
      if (op != 2'b00 && k == 1) exp_ra = rs;
      if (op == 2'b10 && k == 2) exp_ra = rd;
      vectors++;
      if ({cmd_ready, busy, rf_wren, res_valid} !== {1'b0, 1'b1, exp_wren, exp_resv}) begin
        miscompares++;
        $display("FAIL ctl op=%0d cyc=%0d: ready/busy/wren/resv=%b required %b", op, k,
                 {cmd_ready, busy, rf_wren, res_valid}, {1'b0, 1'b1, exp_wren, exp_resv});
      end
      vectors++;
      if ({rf_ra1, rf_ra0} !== exp_ra) begin
        miscompares++;
        $display("FAIL read_addr op=%0d cyc=%0d: ra=%0d required %0d", op, k, {rf_ra1, rf_ra0}, exp_ra);
      end
      if (exp_wren) begin
        vectors++;
        if ({rf_wa1, rf_wa0, rf_din} !== {rd, exp_val}) begin
          miscompares++;
          $display("FAIL write op=%0d: wa=%0d din=%h required wa=%0d din=%h", op,
                   {rf_wa1, rf_wa0}, rf_din, rd, exp_val);
        end
      end
      if (exp_resv) begin
        last_res = res_data;
        vectors++;
        if (res_data !== exp_val) begin
          miscompares++;
          $display("FAIL res_data rs=%0d: got %h required %h", rs, res_data, exp_val);
        end
      end
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    vectors++;
    if ({cmd_ready, busy, rf_wren, res_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL idle_return op=%0d: ready/busy/wren/resv=%b required 1000", op,
               {cmd_ready, busy, rf_wren, res_valid});
    end
    vectors++;
    if ((wr_count - wr0) !== ((op != 2'b11) ? 1 : 0) || (res_count - res0) !== ((op == 2'b11) ? 1 : 0)) begin
      miscompares++;
      $display("FAIL pulse_count op=%0d: writes=%0d results=%0d", op, wr_count - wr0, res_count - res0);
    end
`ifdef CARRY_FLAG_EN
    vectors++;
    if (carry !== exp_carry) begin
      miscompares++;
      $display("FAIL carry op=%0d: got %b required %b", op, carry, exp_carry);
    end
`endif
    ref_carry = exp_carry;
    if (op != 2'b11) ref_rf[rd] = exp_val;
    $display("cmd op=%0d rd=%0d rs=%0d imm=%h hold=%0d -> value %h", op, rd, rs, imm, hold, exp_val);
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = 2'b00; cmd_rs = 2'b00; cmd_imm = '0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({cmd_ready, busy, rf_wren, rf_din, rf_wa1, rf_wa0, rf_ra1, rf_ra0, res_valid, res_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b busy=%b wren=%b din=%h res_valid=%b res_data=%h required all 0",
               cmd_ready, busy, rf_wren, rf_din, res_valid, res_data);
    end
`ifdef CARRY_FLAG_EN
    vectors++;
    if (carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b required 0", carry); end
`endif
    RST = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready); end
    model_clear();
    $display("reset applied and released");
  endtask

  task automatic test_read_after_reset();
    run_cmd(2'b11, 2'b00, 2'd2, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'h0) begin miscompares++; $display("FAIL read_r2_reset: got %h required 0", last_res); end
  endtask

  task automatic test_load_read();
    run_cmd(2'b00, 2'd1, 2'd0, 4'hA, 1'b0);
    run_cmd(2'b11, 2'd0, 2'd1, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'hA) begin miscompares++; $display("FAIL load_read: got %h required A", last_res); end
  endtask

  task automatic test_add_wrap();
    run_cmd(2'b00, 2'd0, 2'd0, 4'h9, 1'b0);
    run_cmd(2'b00, 2'd3, 2'd0, 4'h9, 1'b0);
    run_cmd(2'b10, 2'd0, 2'd3, 4'h0, 1'b0);
`ifdef CARRY_FLAG_EN
    vectors++;
    if (carry !== 1'b1) begin miscompares++; $display("FAIL carry_9p9: got %b required 1", carry); end
`endif
    run_cmd(2'b11, 2'd0, 2'd0, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'h2) begin miscompares++; $display("FAIL add_wrap: got %h required 2", last_res); end
    run_cmd(2'b00, 2'd2, 2'd0, 4'h1, 1'b0);
    run_cmd(2'b10, 2'd2, 2'd2, 4'h0, 1'b0);
`ifdef CARRY_FLAG_EN
    vectors++;
    if (carry !== 1'b0) begin miscompares++; $display("FAIL carry_1p1: got %b required 0", carry); end
`endif
  endtask

  task automatic test_mov_add_self();
    run_cmd(2'b00, 2'd1, 2'd0, 4'hA, 1'b0);
    run_cmd(2'b01, 2'd2, 2'd1, 4'h0, 1'b0);
    run_cmd(2'b11, 2'd0, 2'd2, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'hA) begin miscompares++; $display("FAIL mov_dst: got %h required A", last_res); end
    run_cmd(2'b11, 2'd0, 2'd1, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'hA) begin miscompares++; $display("FAIL mov_src: got %h required A", last_res); end
    run_cmd(2'b00, 2'd1, 2'd0, 4'h3, 1'b0);
    run_cmd(2'b10, 2'd1, 2'd1, 4'h0, 1'b0);
    run_cmd(2'b11, 2'd0, 2'd1, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'h6) begin miscompares++; $display("FAIL add_self: got %h required 6", last_res); end
  endtask

  task automatic test_hold_valid();
    int wr0;
    wr0 = wr_count;
    run_cmd(2'b10, 2'd3, 2'd1, 4'h0, 1'b1);
    repeat (2) @(negedge CLK);
    vectors++;
    if (wr_count - wr0 !== 1) begin
      miscompares++;
      $display("FAIL hold_once: writes=%0d required 1", wr_count - wr0);
    end
  endtask

  task automatic test_reset_mid();
    int wr0, res0, w;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rd = 2'd0; cmd_rs = 2'd1; cmd_imm = '0;
    w = 0;
    while (!cmd_ready && w < 20) begin @(negedge CLK); w++; end
    wr0 = wr_count; res0 = res_count;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({cmd_ready, busy, rf_wren, rf_din, rf_wa1, rf_wa0, rf_ra1, rf_ra0, res_valid, res_data} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ready=%b busy=%b wren=%b din=%h res_data=%h required all 0",
               cmd_ready, busy, rf_wren, rf_din, res_data);
    end
    vectors++;
    if (wr_count != wr0 || res_count != res0) begin
      miscompares++;
      $display("FAIL mid_reset_pulses: writes=%0d results=%0d required 0", wr_count - wr0, res_count - res0);
    end
    RST = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b required 1", cmd_ready); end
    model_clear();
    $display("reset during RD_D of ADD");
    run_cmd(2'b11, 2'd0, 2'd0, 4'h0, 1'b0);
    vectors++;
    if (last_res !== 4'h0) begin miscompares++; $display("FAIL mid_reset_r0: got %h required 0", last_res); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    last_res = '0;
    model_clear();
    test_reset();
    test_read_after_reset();
    test_load_read();
    test_add_wrap();
    test_mov_add_self();
    test_hold_valid();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
